disp_scan_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between two 32-bit hex sources (port 0: CPU result, port 1: debug/aux) and sequences the digit scan. Each scan tick produces one 16-bit frame {dp, seg, sel} and hands it to the serial 74HC595 shifter over a valid/ready handshake. It replaces the free-running scan logic in front of the shifter and adds frame-coherent source arbitration.

---
 rtl/disp_scan_arbiter_pkg.sv | 34 +++
 rtl/disp_scan_arbiter_hex2seg.sv | 32 +++
 rtl/disp_scan_arbiter.sv | 154 +++++++++++++++
 tb/tb_disp_scan_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_scan_arbiter_pkg.sv
// Shared types and constants for the display scan arbiter and related display paths.
//   scan_state_e : scan FSM state encodings
//   frame_t      : 16-bit shifter frame {dp, seg[6:0] active-low gfedcba, sel[7:0] one-hot}
package disp_scan_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } scan_state_e;

  localparam int unsigned FRAME_W             = 16;
  localparam int unsigned FRAME_DP_BIT        = 15;
  localparam int unsigned FRAME_SEG_MSB       = 14;
  localparam int unsigned FRAME_SEG_LSB       = 8;
  localparam int unsigned FRAME_SEL_MSB       = 7;
  localparam int unsigned FRAME_SEL_LSB       = 0;
  localparam int unsigned NUM_DIGITS          = 8;
  localparam int unsigned DIGIT_W             = 3;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned DEFAULT_SCAN_DIV    = 50000;
  localparam int unsigned DEFAULT_HOLD_FRAMES = 4;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
    logic [7:0] sel;
  } frame_t;

  localparam frame_t FRAME_RESET = '{dp: 1'b1, seg: BLANK_SEG, sel: 8'h00};

endpackage

// File: rtl/disp_scan_arbiter_hex2seg.sv
// Combinational hex nibble to active-low seven-segment (gfedcba) decoder.
//   nibble : 4-bit hex value
//   seg_c  : active-low segment pattern, bit 0 = a
module disp_scan_arbiter_hex2seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Digit-scan sequencer for the 8-digit display with frame-coherent arbitration
// between two 32-bit hex sources. One frame per scan tick is handed to the
// 74HC595 shifter over valid/ready.
//   clk, reset          : clock, synchronous active-high reset
//   en                  : scan enable
//   req[1:0]            : source requests
//   data0, data1        : source values
//   grant[1:0]          : one-hot owner, 00 = blank
//   frame_data[15:0]    : {dp, seg, sel}
//   frame_valid/ready   : shifter handshake
//   digit_idx[2:0]      : digit of current/next frame
module disp_scan_arbiter
  import disp_scan_arbiter_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = DEFAULT_SCAN_DIV,
  parameter int unsigned HOLD_FRAMES = DEFAULT_HOLD_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [1:0]  grant,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [2:0]  digit_idx
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          grant_q, grant_d;
  logic [DATA_W-1:0]   snap_q, snap_d;
  frame_t              frame_q, frame_d;
  logic                valid_q, valid_d;

  logic                tick_c;
  logic                hold_sat_c;
  logic                boundary_c;
  logic [1:0]          grant_arb_c;
  logic [DATA_W-1:0]   snap_arb_c;
  logic [DATA_W-1:0]   snap_view_c;
  logic [3:0]          nibble_c;
  logic [6:0]          seg_c;

  assign tick_c      = en && (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign hold_sat_c  = (hold_q >= HOLD_W'(HOLD_FRAMES));
  assign boundary_c  = (digit_q == '0);

  // Owner arbitration evaluated for the frame boundary; only used in LOAD at digit 0.
  always_comb begin
    grant_arb_c = grant_q;
    case (grant_q)
      2'b01: begin
        if (!req[0])                   grant_arb_c = req[1] ? 2'b10 : 2'b00;
        else if (req[1] && hold_sat_c) grant_arb_c = 2'b10;
      end
      2'b10: begin
        if (!req[1])                   grant_arb_c = req[0] ? 2'b01 : 2'b00;
        else if (req[0] && hold_sat_c) grant_arb_c = 2'b01;
      end
      default: grant_arb_c = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
    endcase
    snap_arb_c = grant_arb_c[1] ? data1 : (grant_arb_c[0] ? data0 : '0);
  end

  // At the boundary the frame shows the freshly snapshotted value.
  assign snap_view_c = boundary_c ? snap_arb_c : snap_q;
  assign nibble_c    = snap_view_c[{digit_q, 2'b00} +: 4];

  disp_scan_arbiter_hex2seg u_hex2seg (
    .nibble (nibble_c),
    .seg_c  (seg_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    snap_d  = snap_q;
    frame_d = frame_q;
    valid_d = valid_q;

    if (!en)         cnt_d = '0;
    else if (tick_c) cnt_d = '0;
    else             cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (tick_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (boundary_c) begin
          grant_d = grant_arb_c;
          snap_d  = snap_arb_c;
          if (grant_arb_c != grant_q) hold_d = '0;
        end
        frame_d.dp  = 1'b1;
        frame_d.seg = (grant_d == 2'b00) ? BLANK_SEG : seg_c;
        frame_d.sel = 8'd1 << digit_q;
        valid_d     = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        // Ticks landing here are intentionally dropped.
        if (frame_ready) begin
          valid_d = 1'b0;
          digit_d = digit_q + DIGIT_W'(1);
          if (digit_q == DIGIT_W'(NUM_DIGITS - 1) && !hold_sat_c)
            hold_d = hold_q + HOLD_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      digit_q <= '0;
      hold_q  <= '0;
      grant_q <= 2'b00;
      snap_q  <= '0;
      frame_q <= FRAME_RESET;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign digit_idx   = digit_q;

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Self-checking bench for disp_scan_arbiter: timeline/arbitration reference model
// predicts each frame when it is loaded; a separate monitor pops and compares on
// every accepted frame.
module tb_disp_scan_arbiter;

  localparam int SD = 4;
  localparam int HF = 2;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  req;
  logic [31:0] data0, data1;
  logic [1:0]  grant;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  digit_idx;

  disp_scan_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .grant       (grant),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fd;
    logic [1:0]  g;
    logic [2:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_frames = 0;
  bit   armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int owner);
    return (owner == 1) ? 2'b01 : ((owner == 2) ? 2'b10 : 2'b00);
  endfunction

  // Reference model: tick timeline, arbitration, digit/hold bookkeeping.
  int          mcnt = 0;
  bit          inflight = 0;
  int          valid_at = 0;
  int          m_owner = 0;
  int          m_hold = 0;
  int          m_digit = 0;
  logic [31:0] m_snap = 0;
  bit          prev_rst = 0;
  bit          last_hold = 0;
  logic [15:0] last_fd = 0;

  always @(negedge clk) begin
    bit   exp_valid;
    bit   tick;
    int   nxt;
    int   nib;
    exp_t e;
    cyc++;
    exp_valid = inflight && (cyc >= valid_at);
    if (armed) begin
      if (prev_rst) begin
        check("rst_frame_data", frame_data, 16'hFF00);
        check("rst_valid", frame_valid, 0);
        check("rst_digit", digit_idx, 0);
        check("rst_grant", grant, 0);
      end
      check("valid_timing", frame_valid, exp_valid);
      check("grant_now", grant, onehot(m_owner));
      check("digit_now", digit_idx, m_digit);
      if (last_hold) check("stable_data", frame_data, last_fd);
    end
    last_hold = frame_valid && !frame_ready;
    last_fd   = frame_data;
    tick = en && (mcnt == SD - 1);
    if (reset) begin
      armed = 1; prev_rst = 1; inflight = 0; mcnt = 0;
      m_owner = 0; m_hold = 0; m_digit = 0; m_snap = 0; last_hold = 0;
      exp_q.delete();
    end else begin
      prev_rst = 0;
      if (inflight && cyc == valid_at - 1) begin
        if (m_digit == 0) begin
          nxt = m_owner;
          if (m_owner != 0 && req[m_owner-1]) begin
            if (m_hold >= HF && req[2-m_owner]) nxt = 3 - m_owner;
          end else if (m_owner != 0) begin
            nxt = req[2-m_owner] ? 3 - m_owner : 0;
          end else begin
            nxt = req[0] ? 1 : (req[1] ? 2 : 0);
          end
          if (nxt != m_owner) m_hold = 0;
          m_owner = nxt;
          m_snap  = (nxt == 1) ? data0 : ((nxt == 2) ? data1 : 32'h0);
        end
        nib  = int'((m_snap >> (4 * m_digit)) & 32'hF);
        e.fd = {1'b1, (m_owner == 0) ? 7'h7F : SEG_TAB[nib], 8'(1 << m_digit)};
        e.g  = onehot(m_owner);
        e.d  = 3'(m_digit);
        exp_q.push_back(e);
      end
      if (inflight && exp_valid && frame_ready) begin
        inflight = 0;
        m_digit  = (m_digit + 1) % 8;
        if (m_digit == 0 && m_hold < HF) m_hold++;
      end else if (!inflight && tick) begin
        inflight = 1;
        valid_at = cyc + 2;
      end
      mcnt = !en ? 0 : ((mcnt == SD - 1) ? 0 : mcnt + 1);
    end
  end

  // Monitor: compare every accepted frame with the predicted one.
  always @(negedge clk) begin
    exp_t e;
    if (armed && !reset && frame_valid === 1'b1 && frame_ready) begin
      n_frames++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", frame_data, 16'hxxxx);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", frame_data, e.fd);
        check("frame_grant", grant, e.g);
        check("frame_digit", digit_idx, e.d);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; en = 0; req = 0; data0 = 0; data1 = 0; frame_ready = 1;
    step(3);
    reset = 0; en = 1;
    step(40);                                    // blank scan
    req = 2'b01; data0 = 32'h1234ABCD; data1 = 32'h55AA00FF;
    step(80);                                    // single source
    for (int k = 0; k < 3; k++) begin            // backpressure
      frame_ready = 0; step(10);
      frame_ready = 1; step(12);
    end
    req = 2'b11; data1 = 32'hFEDC0987;
    step(300);                                   // hold and switch
    for (int k = 0; k < 100; k++) begin          // mid-frame data churn
      data0 = $urandom(); step(1);
    end
    for (int k = 0; k < 8; k++) begin            // release at odd points in the frame
      req = 2'($urandom_range(0, 3)); step(37);
    end
    for (int k = 0; k < 4000; k++) begin         // randomized mix
      frame_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) data0 = $urandom();
      if ($urandom_range(0, 7) == 0) data1 = $urandom();
      en = ($urandom_range(0, 99) != 0);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 0; en = 1; frame_ready = 0; req = 2'b01;
    for (int i = 0; i < 50 && !frame_valid; i++) step(1);
    check("pending_before_reset", frame_valid, 1);
    reset = 1; step(1);                          // reset mid-handshake
    reset = 0; step(2);
    for (int i = 0; i < 50 && !frame_valid; i++) step(1);
    check("pending_before_en_off", frame_valid, 1);
    en = 0; step(5);
    frame_ready = 1; step(40);                   // no new frames with en=0
    check("frames_seen", (n_frames >= 300) ? 1 : 0, 1);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
